risc_v_run_ctrl: RTL and testbench

Execution controller for the single-cycle RISC-V core. It sequences the datapath through reset-hold, halt, free-run, single-step and breakpoint states. It produces one clock-enable (`CPU_EN`) that gates PC update, `REG_WRITE` and `MEM_WRITE` in `RISC_V_UNDER_TOP`, counts retired instructions, and shows the controller state on `HEX0`. Board switches `SW[3:0]` are the operator interface.

---
 rtl/risc_v_ctrl_pkg.sv | 36 +++
 rtl/switch_sync_edge.sv | 42 ++++
 rtl/risc_v_run_ctrl.sv | 127 ++++++++++++
 tb/tb_risc_v_run_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_ctrl_pkg.sv
// Shared types and constants for the RISC-V run controller:
// controller state codes, EBREAK encoding and seven-segment glyphs.
package risc_v_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_HALT       = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_BREAK      = 3'd4
  } run_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_0    = 7'b100_0000;
  localparam logic [6:0] SEG_1    = 7'b111_1001;
  localparam logic [6:0] SEG_2    = 7'b010_0100;
  localparam logic [6:0] SEG_3    = 7'b011_0000;
  localparam logic [6:0] SEG_4    = 7'b001_1001;
  localparam logic [6:0] SEG_DASH = 7'b011_1111;

  function automatic logic [6:0] state_to_seg(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'd0:    seg = SEG_0;
      3'd1:    seg = SEG_1;
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/switch_sync_edge.sv
// N-flop synchronizer for one asynchronous switch input, with an optional
// one-cycle rising-edge pulse taken from the synchronized level.
module switch_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          EDGE_EN = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign level_o = sync_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= level_o;
      end
    end

    assign rise_o = level_o & ~prev_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/risc_v_run_ctrl.sv
// Execution controller for the single-cycle RISC-V core: reset hold, halt,
// free-run, single-step and breakpoint sequencing plus a retired-instruction counter.
module risc_v_run_ctrl
  import risc_v_ctrl_pkg::*;
#(
  parameter logic [31:0] BP_ADDR     = 32'h0000_0040,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  SW,
  input  logic [31:0] PC,
  input  logic [31:0] INST_DATA,
  output logic        CPU_EN,
  output logic        HALTED,
  output logic [2:0]  STATE,
  output logic [31:0] RETIRE_CNT,
  output logic [6:0]  HEX0
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [3:0] sw_lvl;
  logic [3:0] sw_rise;

  for (genvar i = 0; i < 4; i++) begin : g_sw
    switch_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .EDGE_EN ((i == 1) || (i == 3))
    ) u_sync (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .d_i     (SW[i]),
      .level_o (sw_lvl[i]),
      .rise_o  (sw_rise[i])
    );
  end

  logic sync_unused;
  assign sync_unused = ^{sw_lvl[1], sw_lvl[3], sw_rise[0], sw_rise[2]};

  logic run_lvl, bp_en, step_p, clr_p, bp_hit, ebrk, en;

  assign run_lvl = sw_lvl[0];
  assign bp_en   = sw_lvl[2];
  assign step_p  = sw_rise[1];
  assign clr_p   = sw_rise[3];
  assign bp_hit  = bp_en && (PC == BP_ADDR);
  assign ebrk    = (INST_DATA == EBREAK_INST);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RESET_HOLD;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step pulses are only consumed in HALT/BREAK, so any pulse produced by a
  // switch held through reset release expires while still in RESET_HOLD.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    en      = 1'b0;
    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (run_lvl) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        en = !(bp_hit || ebrk);
        if (bp_hit || ebrk) begin
          state_d = ST_BREAK;
        end else if (!run_lvl) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        en      = !ebrk;
        state_d = ebrk ? ST_BREAK : ST_HALT;
      end
      ST_BREAK: begin
        if (step_p) begin
          state_d = ST_STEP;
        end else if (!run_lvl) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_p) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign CPU_EN     = en;
  assign HALTED     = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign STATE      = state_q;
  assign RETIRE_CNT = cnt_q;
  assign HEX0       = state_to_seg(state_q);

endmodule

// File: tb/tb_risc_v_run_ctrl.sv
// Directed and randomized bench for risc_v_run_ctrl against a cycle-level
// reference model built from the switch history and the controller rules.
module tb_risc_v_run_ctrl;

  localparam logic [31:0] BP   = 32'h0000_0040;
  localparam int          S    = 2;
  localparam int          HOLD = 4;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  localparam int M_HOLD  = 0;
  localparam int M_HALT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_STEP  = 3;
  localparam int M_BREAK = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  SW = '0;
  logic [31:0] PC = '0;
  logic [31:0] INST_DATA = '0;
  logic        CPU_EN;
  logic        HALTED;
  logic [2:0]  STATE;
  logic [31:0] RETIRE_CNT;
  logic [6:0]  HEX0;

  int vectors = 0;
  int miscompares = 0;

  int          m_state;
  int          m_hold;
  logic [31:0] m_cnt;
  logic [3:0]  sw_hist[$];
  logic        auto_pc = 1'b0;
  logic [6:0]  hex_tab[0:4];

  always #5 CLK = ~CLK;

  risc_v_run_ctrl #(
    .BP_ADDR     (BP),
    .SYNC_STAGES (S),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW         (SW),
    .PC         (PC),
    .INST_DATA  (INST_DATA),
    .CPU_EN     (CPU_EN),
    .HALTED     (HALTED),
    .STATE      (STATE),
    .RETIRE_CNT (RETIRE_CNT),
    .HEX0       (HEX0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Synchronized switch word seen by the controller: the value that was on SW
  // S edges ago (back=1 gives the cycle before). Zero until enough history.
  function automatic logic [3:0] sync_at(input int back);
    if (sw_hist.size() >= S + back) return sw_hist[sw_hist.size() - S - back];
    return 4'b0000;
  endfunction

  task automatic model_eval(output logic en, output int nxt, output logic clr);
    logic [3:0] cur, prv;
    logic run, stp, bp, eb;
    cur = sync_at(0);
    prv = sync_at(1);
    run = cur[0];
    stp = cur[1] & ~prv[1];
    clr = cur[3] & ~prv[3];
    bp  = cur[2] && (PC == BP);
    eb  = (INST_DATA == EBRK);
    en  = 1'b0;
    nxt = m_state;
    case (m_state)
      M_HOLD:  nxt = (m_hold + 1 == HOLD) ? M_HALT : M_HOLD;
      M_HALT:  if (run) nxt = M_RUN; else if (stp) nxt = M_STEP;
      M_RUN: begin
        en = !(bp || eb);
        if (bp || eb) nxt = M_BREAK; else if (!run) nxt = M_HALT;
      end
      M_STEP: begin
        en  = !eb;
        nxt = eb ? M_BREAK : M_HALT;
      end
      M_BREAK: if (stp) nxt = M_STEP; else if (!run) nxt = M_HALT;
      default: nxt = M_HOLD;
    endcase
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    logic en, clr;
    int   nxt;
    #1;
    model_eval(en, nxt, clr);
    chk("cpu_en", {31'b0, CPU_EN}, {31'b0, en});
    chk("state", {29'b0, STATE}, 32'(m_state));
    chk("halted", {31'b0, HALTED}, {31'b0, (m_state == M_HALT) || (m_state == M_BREAK)});
    chk("hex0", {25'b0, HEX0}, {25'b0, hex_tab[m_state]});
    chk("retire_cnt", RETIRE_CNT, m_cnt);
    @(posedge CLK);
    sw_hist.push_back(SW);
    if (m_state == M_HOLD) m_hold++;
    if (clr) m_cnt = '0;
    else if (en) m_cnt = m_cnt + 32'd1;
    m_state = nxt;
    @(negedge CLK);
    if (auto_pc && en) PC = PC + 32'd4;
  endtask

  task automatic apply_reset(input int edges);
    #2 RST = 1'b0;
    #1;
    chk("rst_cpu_en", {31'b0, CPU_EN}, 32'd0);
    chk("rst_retire_cnt", RETIRE_CNT, 32'd0);
    chk("rst_state", {29'b0, STATE}, 32'd0);
    chk("rst_halted", {31'b0, HALTED}, 32'd0);
    chk("rst_hex0", {25'b0, HEX0}, {25'b0, 7'b1000000});
    m_state = M_HOLD;
    m_hold  = 0;
    m_cnt   = '0;
    sw_hist.delete();
    repeat (edges) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    // Power-on reset and hold window
    apply_reset(3);
    repeat (6) cyc();
    chk("hold_done_state", {29'b0, STATE}, 32'd1);
    chk("hold_done_hex0", {25'b0, HEX0}, {25'b0, 7'b1111001});

    // Three single steps from HALT
    for (int n = 0; n < 3; n++) begin
      SW[1] = 1'b1;
      repeat (3) cyc();
      SW[1] = 1'b0;
      repeat (4) cyc();
    end
    chk("step_count", RETIRE_CNT, 32'd3);

    // Counter clear
    SW[3] = 1'b1;
    repeat (3) cyc();
    SW[3] = 1'b0;
    repeat (3) cyc();
    chk("clr_count", RETIRE_CNT, 32'd0);

    // Breakpoint sweep, then leave the breakpoint by stepping
    auto_pc = 1'b1;
    PC = 32'd0;
    SW = 4'b0101;
    repeat (25) cyc();
    chk("bp_state", {29'b0, STATE}, 32'd4);
    chk("bp_count", RETIRE_CNT, 32'd16);
    SW = 4'b0100;
    repeat (4) cyc();
    SW[1] = 1'b1;
    repeat (3) cyc();
    SW[1] = 1'b0;
    repeat (3) cyc();
    chk("bp_step_count", RETIRE_CNT, 32'd17);
    chk("bp_step_state", {29'b0, STATE}, 32'd1);

    // EBREAK in RUN, then step on the same instruction
    INST_DATA = EBRK;
    SW = 4'b0001;
    repeat (5) cyc();
    chk("ebrk_state", {29'b0, STATE}, 32'd4);
    SW[1] = 1'b1;
    repeat (3) cyc();
    SW[1] = 1'b0;
    repeat (3) cyc();
    chk("ebrk_step_state", {29'b0, STATE}, 32'd4);
    chk("ebrk_count", RETIRE_CNT, 32'd17);
    INST_DATA = '0;
    SW = 4'b0000;
    repeat (4) cyc();

    // Counter wrap from all-ones, then clear during increments
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    PC = 32'h0000_1000;
    SW = 4'b0001;
    repeat (6) cyc();
    SW[3] = 1'b1;
    repeat (3) cyc();
    SW[3] = 1'b0;
    repeat (3) cyc();
    SW = 4'b0000;
    repeat (4) cyc();

    // Randomized operation
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) SW = 4'($urandom);
      INST_DATA = ($urandom_range(0, 7) == 0) ? EBRK : $urandom;
      if ($urandom_range(0, 9) == 0) PC = BP;
      else if ($urandom_range(0, 19) == 0) PC = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    // Asynchronous reset mid-run with STEP held through release
    INST_DATA = '0;
    PC = 32'h0000_0100;
    SW = 4'b0001;
    repeat (6) cyc();
    SW = 4'b0010;
    apply_reset(2);
    repeat (10) cyc();
    chk("no_step_after_rst", {29'b0, STATE}, 32'd1);
    chk("no_exec_after_rst", RETIRE_CNT, 32'd0);
    SW = 4'b0000;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
